snoopy_lock_client: RTL and testbench
=====================================

Name: snoopy_lock_client

Overview:
- Per-processor requester that sits directly upstream of the snoopy bus arbiter. One instance per processor, indexed i.
- Accepts lock/unlock commands from its processor and drives snoopy_bus_request[i] to the arbiter.
- Once granted, broadcasts the key on the snoopy bus and collects hit responses from all other clients.
- Grants or refuses the lock, then pulses snoopy_bus_release[i]. Also snoops other clients' broadcasts against its own held key.

Parameters:
- KEY_WIDTH, 32, width of lockable key.
- CNT_WIDTH, 16, width of the saturating statistics counters.

Ports:
- clk  in  1  sole clock
- reset_n  in  1  asynchronous, active-low reset
- lock_req  in  1  processor lock command (sampled in IDLE only)
- lock_key  in  KEY_WIDTH  key to lock, sampled with lock_req
- unlock_req  in  1  processor releases its held key
- lock_ack  out  1  one-cycle pulse: lock obtained
- lock_nack  out  1  one-cycle pulse: lock refused
- unlock_ack  out  1  one-cycle pulse: unlock done
- held_valid  out  1  client currently holds a key
- held_key  out  KEY_WIDTH  key currently held
- snoopy_bus_request  out  1  to arbiter request[i]
- snoopy_bus_grant  in  1  from arbiter grant[i]
- snoopy_bus_release  out  1  to arbiter release[i]
- bus_valid_out  out  1  key broadcast strobe (OR-ed across clients onto bus)
- bus_key_out  out  KEY_WIDTH  broadcast key (zero when not broadcasting; OR-ed onto bus)
- snoop_valid  in  1  bus broadcast strobe
- snoop_key  in  KEY_WIDTH  bus broadcast key
- snoop_hit  out  1  this client holds snoop_key (registered)
- snoop_hit_in  in  1  OR of all clients' snoop_hit
- nack_count  out  CNT_WIDTH  saturating count of lock_nack pulses
- ack_count  out  CNT_WIDTH  saturating count of lock_ack pulses

Behaviour:
- Reset (reset_n low, async): state=IDLE. All outputs are 0, including held_valid, held_key and both counters.
- A reset asserted mid-transaction drops request/release immediately and loses the held key.

State machine: IDLE, REQ, BCAST, COLLECT, RELEASE.

IDLE:
- unlock_req has priority over lock_req when both are asserted in the same cycle.
- unlock_req: clear held_valid and held_key next cycle, pulse unlock_ack next cycle. If nothing is held, unlock_ack is still pulsed (no-op).
- lock_req with held_valid=1: pulse lock_nack next cycle, no bus activity, remain IDLE. Only one key may be held.
- lock_req with held_valid=0: latch lock_key, go to REQ.

REQ:
- snoopy_bus_request=1, held continuously until the RELEASE cycle.
- Wait for snoopy_bus_grant. There is no timeout.
- lock_req and unlock_req are ignored in REQ, BCAST, COLLECT and RELEASE.

BCAST:
- Entered the cycle after grant is seen.
- Exactly one cycle with bus_valid_out=1 and bus_key_out=latched key.

COLLECT:
- Sample snoop_hit_in; the other clients' registered hits arrive in this cycle.
- Hit=1: pulse lock_nack.
- Hit=0: set held_valid=1 and held_key=key, pulse lock_ack. Both outputs are visible the next cycle, together with the pulse.

RELEASE:
- snoopy_bus_release=1 and snoopy_bus_request=0 for one cycle, then IDLE.
- Request-to-ack latency = grant wait + 3 cycles after grant.

Snoop path (independent of state):
- snoop_hit(t+1) = snoop_valid(t) & held_valid(t) & (snoop_key(t)==held_key(t)).
- Compare uses the pre-update held value. An unlock in the same cycle as a matching broadcast still reports a hit, which is conservative.
- The client never hits on its own broadcast, because it holds nothing while requesting.

Counters:
- Increment on each lock_ack / lock_nack pulse; saturate at all-ones with no wrap.

Decomposition:
- Package snoopy_pkg holds:
  - the state typedef enum;
  - the default KEY_WIDTH / CNT_WIDTH constants;
  - the log2 function shared with the arbiter.
- Sub-module snoopy_key_matcher: the registered comparator producing snoop_hit from snoop_valid, snoop_key, held_valid and held_key.

Test Plan:
1. Lock key 0x1234 with no other holders, grant 2 cycles after request. Required: bus_valid_out for one cycle with key 0x1234; lock_ack 3 cycles after grant; held_key=0x1234; release pulsed once; ack_count=1.
2. Lock 0x55 with snoop_hit_in=1 in COLLECT. Required: lock_nack pulse, held_valid stays 0, release still pulsed, nack_count=1.
3. Holding 0xAA, snoop_valid with snoop_key=0xAA. Required: snoop_hit=1 exactly one cycle later. snoop_key=0xAB → snoop_hit=0.
4. Holding 0xAA, issue lock_req. Required: lock_nack next cycle, snoopy_bus_request never asserted. Then unlock_req → unlock_ack, held_valid=0.
5. lock_req and unlock_req together in IDLE while holding. Required: unlock wins, lock ignored.
6. reset_n low during BCAST. Required: bus_valid_out and snoopy_bus_request drop asynchronously, all outputs 0. Force nack_count to saturate at 0xFFFF without wrapping.

Source files
------------

// File: rtl/snoopy_pkg.sv
// Shared types and constants for the snoopy lock client and its arbiter.
package snoopy_pkg;

  localparam int DEF_KEY_WIDTH = 32;
  localparam int DEF_CNT_WIDTH = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_REQ     = 3'd1,
    ST_BCAST   = 3'd2,
    ST_COLLECT = 3'd3,
    ST_RELEASE = 3'd4
  } state_t;

  // Ceiling log2, also used to size the arbiter's grant index.
  function automatic int log2_ceil(input int value);
    int result;
    result = 0;
    while ((1 << result) < value) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/snoopy_key_matcher.sv
// Registered snoop comparator: flags a broadcast that matches the key this client holds.
module snoopy_key_matcher
  import snoopy_pkg::*;
#(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 snoop_valid,
  input  logic [KEY_WIDTH-1:0] snoop_key,
  input  logic                 held_valid,
  input  logic [KEY_WIDTH-1:0] held_key,
  output logic                 snoop_hit
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      snoop_hit <= 1'b0;
    end else begin
      snoop_hit <= snoop_valid & held_valid & (snoop_key == held_key);
    end
  end

endmodule

// File: rtl/snoopy_lock_client.sv
// Per-processor lock requester: arbitrates for the snoopy bus, broadcasts its key,
// collects hits from the other clients and grants or refuses the lock.
module snoopy_lock_client
  import snoopy_pkg::*;
#(
  parameter int KEY_WIDTH = DEF_KEY_WIDTH,
  parameter int CNT_WIDTH = DEF_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 lock_req,
  input  logic [KEY_WIDTH-1:0] lock_key,
  input  logic                 unlock_req,
  output logic                 lock_ack,
  output logic                 lock_nack,
  output logic                 unlock_ack,
  output logic                 held_valid,
  output logic [KEY_WIDTH-1:0] held_key,
  output logic                 snoopy_bus_request,
  input  logic                 snoopy_bus_grant,
  output logic                 snoopy_bus_release,
  output logic                 bus_valid_out,
  output logic [KEY_WIDTH-1:0] bus_key_out,
  input  logic                 snoop_valid,
  input  logic [KEY_WIDTH-1:0] snoop_key,
  output logic                 snoop_hit,
  input  logic                 snoop_hit_in,
  output logic [CNT_WIDTH-1:0] nack_count,
  output logic [CNT_WIDTH-1:0] ack_count
);

  state_t               state_reg, state_next;
  logic [KEY_WIDTH-1:0] key_reg, key_next;
  logic                 held_valid_reg, held_valid_next;
  logic [KEY_WIDTH-1:0] held_key_reg, held_key_next;
  logic                 lock_ack_reg, lock_ack_next;
  logic                 lock_nack_reg, lock_nack_next;
  logic                 unlock_ack_reg, unlock_ack_next;
  logic [CNT_WIDTH-1:0] ack_count_reg, ack_count_next;
  logic [CNT_WIDTH-1:0] nack_count_reg, nack_count_next;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= ST_IDLE;
      key_reg        <= '0;
      held_valid_reg <= 1'b0;
      held_key_reg   <= '0;
      lock_ack_reg   <= 1'b0;
      lock_nack_reg  <= 1'b0;
      unlock_ack_reg <= 1'b0;
      ack_count_reg  <= '0;
      nack_count_reg <= '0;
    end else begin
      state_reg      <= state_next;
      key_reg        <= key_next;
      held_valid_reg <= held_valid_next;
      held_key_reg   <= held_key_next;
      lock_ack_reg   <= lock_ack_next;
      lock_nack_reg  <= lock_nack_next;
      unlock_ack_reg <= unlock_ack_next;
      ack_count_reg  <= ack_count_next;
      nack_count_reg <= nack_count_next;
    end
  end

  always_comb begin
    state_next      = state_reg;
    key_next        = key_reg;
    held_valid_next = held_valid_reg;
    held_key_next   = held_key_reg;
    lock_ack_next   = 1'b0;
    lock_nack_next  = 1'b0;
    unlock_ack_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        // Unlock wins over a simultaneous lock; unlocking nothing is still acknowledged.
        if (unlock_req) begin
          held_valid_next = 1'b0;
          held_key_next   = '0;
          unlock_ack_next = 1'b1;
        end else if (lock_req) begin
          if (held_valid_reg) begin
            lock_nack_next = 1'b1;
          end else begin
            key_next   = lock_key;
            state_next = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        if (snoopy_bus_grant) begin
          state_next = ST_BCAST;
        end
      end
      ST_BCAST: begin
        state_next = ST_COLLECT;
      end
      ST_COLLECT: begin
        if (snoop_hit_in) begin
          lock_nack_next = 1'b1;
        end else begin
          held_valid_next = 1'b1;
          held_key_next   = key_reg;
          lock_ack_next   = 1'b1;
        end
        state_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        state_next = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Counters advance in the same cycle their pulse becomes visible and stick at all-ones.
  always_comb begin
    ack_count_next  = ack_count_reg;
    nack_count_next = nack_count_reg;
    if (lock_ack_next && (ack_count_reg != '1)) begin
      ack_count_next = ack_count_reg + CNT_WIDTH'(1);
    end
    if (lock_nack_next && (nack_count_reg != '1)) begin
      nack_count_next = nack_count_reg + CNT_WIDTH'(1);
    end
  end

  assign snoopy_bus_request = (state_reg == ST_REQ) || (state_reg == ST_BCAST) ||
                              (state_reg == ST_COLLECT);
  assign snoopy_bus_release = (state_reg == ST_RELEASE);
  assign bus_valid_out      = (state_reg == ST_BCAST);
  assign bus_key_out        = (state_reg == ST_BCAST) ? key_reg : '0;

  assign lock_ack   = lock_ack_reg;
  assign lock_nack  = lock_nack_reg;
  assign unlock_ack = unlock_ack_reg;
  assign held_valid = held_valid_reg;
  assign held_key   = held_key_reg;
  assign ack_count  = ack_count_reg;
  assign nack_count = nack_count_reg;

  snoopy_key_matcher #(
    .KEY_WIDTH(KEY_WIDTH)
  ) u_matcher (
    .clk        (clk),
    .reset_n    (reset_n),
    .snoop_valid(snoop_valid),
    .snoop_key  (snoop_key),
    .held_valid (held_valid_reg),
    .held_key   (held_key_reg),
    .snoop_hit  (snoop_hit)
  );

endmodule

// File: tb/tb_snoopy_lock_client.sv
// Scoreboard bench for snoopy_lock_client: transaction-level model plus an event monitor.
module tb_snoopy_lock_client;

  localparam int KW      = 32;
  localparam int CW      = 16;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          lock_req = 1'b0;
  logic [KW-1:0] lock_key = '0;
  logic          unlock_req = 1'b0;
  logic          lock_ack, lock_nack, unlock_ack, held_valid;
  logic [KW-1:0] held_key;
  logic          snoopy_bus_request;
  logic          snoopy_bus_grant = 1'b0;
  logic          snoopy_bus_release;
  logic          bus_valid_out;
  logic [KW-1:0] bus_key_out;
  logic          snoop_valid = 1'b0;
  logic [KW-1:0] snoop_key = '0;
  logic          snoop_hit;
  logic          snoop_hit_in = 1'b0;
  logic [CW-1:0] nack_count, ack_count;

  snoopy_lock_client #(.KEY_WIDTH(KW), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .lock_req(lock_req), .lock_key(lock_key),
    .unlock_req(unlock_req), .lock_ack(lock_ack), .lock_nack(lock_nack),
    .unlock_ack(unlock_ack), .held_valid(held_valid), .held_key(held_key),
    .snoopy_bus_request(snoopy_bus_request), .snoopy_bus_grant(snoopy_bus_grant),
    .snoopy_bus_release(snoopy_bus_release), .bus_valid_out(bus_valid_out),
    .bus_key_out(bus_key_out), .snoop_valid(snoop_valid), .snoop_key(snoop_key),
    .snoop_hit(snoop_hit), .snoop_hit_in(snoop_hit_in), .nack_count(nack_count),
    .ack_count(ack_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int          cyc;
    bit          ack, nack, uack, bvalid, rel;
    logic [KW-1:0] bkey;
    bit          hv;
    logic [KW-1:0] hk;
    int          acnt, ncnt;
  } ev_t;
  typedef struct {
    int cyc;
    bit hit;
  } hit_t;

  ev_t  ev_q[$];
  hit_t hit_q[$];

  // Reference model: what the client holds and how many acks/nacks it has issued.
  bit          m_hv = 1'b0;
  logic [KW-1:0] m_hk = '0;
  int          m_acnt = 0;
  int          m_ncnt = 0;
  int          req_cycles = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  function automatic void push_ev(input int c, input bit ack, input bit nack, input bit uack,
                                  input bit bvalid, input bit rel, input logic [KW-1:0] bkey);
    ev_t e;
    e.cyc = c; e.ack = ack; e.nack = nack; e.uack = uack; e.bvalid = bvalid; e.rel = rel;
    e.bkey = bkey; e.hv = m_hv; e.hk = m_hk; e.acnt = m_acnt; e.ncnt = m_ncnt;
    ev_q.push_back(e);
  endfunction

  function automatic void push_hit(input int c, input logic [KW-1:0] key);
    hit_t h;
    h.cyc = c;
    h.hit = m_hv && (key == m_hk);
    hit_q.push_back(h);
  endfunction

  // Monitor: pops the scoreboard whenever the DUT presents any strobe.
  always @(negedge clk) begin
    ev_t  e;
    hit_t h;
    if (reset_n) begin
      if (snoopy_bus_request) req_cycles++;
      if (lock_ack | lock_nack | unlock_ack | bus_valid_out | snoopy_bus_release) begin
        if (ev_q.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_event actual=ack%0b nack%0b uack%0b bv%0b rel%0b required=none cycle=%0d",
                   lock_ack, lock_nack, unlock_ack, bus_valid_out, snoopy_bus_release, cyc);
        end else begin
          e = ev_q.pop_front();
          chk("event_cycle", cyc, e.cyc);
          chk("lock_ack", lock_ack, e.ack);
          chk("lock_nack", lock_nack, e.nack);
          chk("unlock_ack", unlock_ack, e.uack);
          chk("bus_valid_out", bus_valid_out, e.bvalid);
          chk("bus_release", snoopy_bus_release, e.rel);
          chk("bus_key_out", bus_key_out, e.bkey);
          chk("held_valid", held_valid, e.hv);
          chk("held_key", held_key, e.hk);
          chk("ack_count", ack_count, e.acnt);
          chk("nack_count", nack_count, e.ncnt);
        end
      end else if (ev_q.size() > 0 && ev_q[0].cyc <= cyc) begin
        e = ev_q.pop_front();
        checks++; failures++;
        $display("FAIL missing_event actual=none required=event_at_cycle_%0d cycle=%0d", e.cyc, cyc);
      end
      if (hit_q.size() > 0 && hit_q[0].cyc == cyc) begin
        h = hit_q.pop_front();
        chk("snoop_hit", snoop_hit, h.hit);
      end else if (snoop_hit) begin
        checks++; failures++;
        $display("FAIL unexpected_snoop_hit actual=1 required=0 cycle=%0d", cyc);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_lock(input logic [KW-1:0] key, input int dly, input bit other_hit);
    int c;
    lock_key = key;
    lock_req = 1'b1;
    if (m_hv) begin
      if (m_ncnt < CNT_MAX) m_ncnt++;
      push_ev(cyc + 1, 0, 1, 0, 0, 0, '0);
      step();
      lock_req = 1'b0;
      chk("no_request_when_held", snoopy_bus_request, 1'b0);
    end else begin
      step();
      lock_req = 1'b0;
      snoop_hit_in = other_hit;
      chk("request_raised", snoopy_bus_request, 1'b1);
      repeat (dly) step();
      snoopy_bus_grant = 1'b1;
      c = cyc;
      push_ev(c + 1, 0, 0, 0, 1, 0, key);
      if (other_hit) begin
        if (m_ncnt < CNT_MAX) m_ncnt++;
      end else begin
        m_hv = 1'b1; m_hk = key;
        if (m_acnt < CNT_MAX) m_acnt++;
      end
      push_ev(c + 3, !other_hit, other_hit, 0, 0, 1, '0);
      step();
      snoopy_bus_grant = 1'b0;
      repeat (3) step();
      snoop_hit_in = 1'b0;
    end
  endtask

  task automatic do_unlock(input bit with_lock, input logic [KW-1:0] lkey,
                           input bit with_snoop, input logic [KW-1:0] skey);
    unlock_req = 1'b1;
    lock_req = with_lock;
    lock_key = lkey;
    if (with_snoop) begin
      snoop_valid = 1'b1;
      snoop_key = skey;
      push_hit(cyc + 1, skey);
    end
    m_hv = 1'b0; m_hk = '0;
    push_ev(cyc + 1, 0, 0, 1, 0, 0, '0);
    step();
    unlock_req = 1'b0; lock_req = 1'b0; snoop_valid = 1'b0;
  endtask

  task automatic probe(input logic [KW-1:0] key);
    snoop_valid = 1'b1;
    snoop_key = key;
    push_hit(cyc + 1, key);
    step();
    snoop_valid = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_lock_ack"}, lock_ack, 0);
    chk({tag, "_lock_nack"}, lock_nack, 0);
    chk({tag, "_unlock_ack"}, unlock_ack, 0);
    chk({tag, "_held_valid"}, held_valid, 0);
    chk({tag, "_held_key"}, held_key, 0);
    chk({tag, "_request"}, snoopy_bus_request, 0);
    chk({tag, "_release"}, snoopy_bus_release, 0);
    chk({tag, "_bus_valid"}, bus_valid_out, 0);
    chk({tag, "_bus_key"}, bus_key_out, 0);
    chk({tag, "_snoop_hit"}, snoop_hit, 0);
    chk({tag, "_ack_count"}, ack_count, 0);
    chk({tag, "_nack_count"}, nack_count, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish cycle=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    logic [KW-1:0] k;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset_n = 1'b1;
    step();

    // Directed: plain lock, bus-side refusal, snoop hits, local refusal, unlock priority.
    do_lock(32'h1234, 2, 1'b0);
    chk("t1_held_key", held_key, 32'h1234);
    chk("t1_ack_count", ack_count, 1);
    do_unlock(1'b0, '0, 1'b0, '0);
    do_lock(32'h55, 1, 1'b1);
    chk("t2_held_valid", held_valid, 0);
    chk("t2_nack_count", nack_count, 1);
    do_lock(32'hAA, 0, 1'b0);
    probe(32'hAA);
    probe(32'hAB);
    snap = req_cycles;
    do_lock(32'hBB, 0, 1'b0);
    repeat (3) step();
    chk("t4_no_bus_request", req_cycles, snap);
    do_unlock(1'b0, '0, 1'b0, '0);
    chk("t4_held_valid", held_valid, 0);
    do_lock(32'hCC, 1, 1'b0);
    snap = req_cycles;
    do_unlock(1'b1, 32'hDD, 1'b1, 32'hCC);
    repeat (4) step();
    chk("t5_lock_ignored", req_cycles, snap);
    probe(32'hCC);

    // Randomized mix against the model.
    for (int i = 0; i < 80; i++) begin
      k = 32'h10 + KW'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0, 1: do_lock(k, int'($urandom_range(0, 3)), $urandom_range(0, 2) == 0);
        2:    do_unlock($urandom_range(0, 1) == 1, k, $urandom_range(0, 1) == 1,
                        ($urandom_range(0, 1) == 1) ? m_hk : k);
        default: probe(($urandom_range(0, 1) == 1) ? m_hk : k);
      endcase
    end
    repeat (3) step();

    // Reset in the middle of a broadcast.
    do_unlock(1'b0, '0, 1'b0, '0);
    lock_key = 32'hEE;
    lock_req = 1'b1;
    step();
    lock_req = 1'b0;
    snoopy_bus_grant = 1'b1;
    push_ev(cyc + 1, 0, 0, 0, 1, 0, 32'hEE);
    step();
    snoopy_bus_grant = 1'b0;
    @(negedge clk);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    ev_q.delete();
    hit_q.delete();
    m_hv = 1'b0; m_hk = '0; m_acnt = 0; m_ncnt = 0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step();

    // Saturate the nack counter by holding lock_req while a key is held.
    do_lock(32'h77, 0, 1'b0);
    lock_key = 32'h99;
    lock_req = 1'b1;
    for (int i = 0; i < CNT_MAX + 5; i++) begin
      if (m_ncnt < CNT_MAX) m_ncnt++;
      push_ev(cyc + 1, 0, 1, 0, 0, 0, '0);
      step();
    end
    lock_req = 1'b0;
    repeat (3) step();
    chk("nack_saturated", nack_count, 16'hFFFF);
    chk("held_after_saturation", held_key, 32'h77);
    chk("event_queue_drained", ev_q.size(), 0);
    chk("hit_queue_drained", hit_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
